// File: rtl/matrix_pkg.sv
// Shared constants and loader state encoding for the LED matrix scan controller.
package matrix_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [0:0] {
    StIdle,
    StLoad
  } load_state_e;

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-cycle tick every SCAN_DIV clock cycles.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic i_clk_sys,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == CntW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// LED matrix column scanner with double-buffered frame loader fed by a byte stream.
// Frames start with SOF; a completed frame becomes visible at the next column wrap.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS        = 16,
  parameter int unsigned COLS        = 16,
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                     i_clk_sys,
  input  logic                     i_rst_n,
  input  logic                     i_rx_valid,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_perr,
  input  logic                     i_blank,
  output logic [ROWS-1:0]          o_data_col,
  output logic [$clog2(COLS)-1:0]  o_curr_col,
  output logic                     o_frame_done,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam int unsigned BPC    = ROWS / 8;
  localparam int unsigned NBYTES = COLS * BPC;
  localparam int unsigned ColW   = $clog2(COLS);
  localparam int unsigned IdxW   = $clog2(NBYTES);
  localparam int unsigned ToW    = $clog2(TIMEOUT_CYC + 1);

  load_state_e     state_q, state_d;
  logic            swap_pending_q;
  logic            front_sel_q;
  logic [IdxW-1:0] byte_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic [7:0]      fb_q [2][NBYTES];

  logic            tick;
  logic [ColW-1:0] col_d;
  logic            swap;
  logic            sel_new;
  logic [ROWS-1:0] col_pat;

  logic in_load, rx_ok, sof_seen, timeout_hit;
  logic load_wr, load_last, load_abort, sof_reject;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .o_tick    (tick)
  );

  assign in_load     = (state_q == StLoad);
  assign rx_ok       = i_rx_valid && !i_rx_perr;
  assign sof_seen    = rx_ok && (i_rx_data == SOF);
  assign timeout_hit = !i_rx_valid && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));
  assign load_wr     = in_load && rx_ok;
  assign load_last   = load_wr && (byte_cnt_q == IdxW'(NBYTES - 1));
  assign load_abort  = in_load && ((i_rx_valid && i_rx_perr) || timeout_hit);
  assign sof_reject  = !in_load && sof_seen && swap_pending_q;

  // Loader FSM: state register
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Loader FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (sof_seen && !swap_pending_q) state_d = StLoad;
      StLoad: if (load_abort || load_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Loader FSM: outputs
  always_comb begin
    o_busy = in_load || swap_pending_q;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      if (!in_load || load_last || load_abort) begin
        byte_cnt_q <= '0;
      end else if (load_wr) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (!in_load || i_rx_valid) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned k = 0; k < NBYTES; k++) begin
          fb_q[s][k] <= '0;
        end
      end
    end else if (load_wr) begin
      fb_q[~front_sel_q][byte_cnt_q] <= i_rx_data;
    end
  end

  assign col_d   = (o_curr_col == ColW'(COLS - 1)) ? '0 : o_curr_col + 1'b1;
  assign swap    = tick && (col_d == '0) && swap_pending_q;
  // Column 0 of a swap tick is read from the incoming front buffer.
  assign sel_new = front_sel_q ^ swap;

  always_comb begin
    col_pat = '0;
    for (int unsigned b = 0; b < BPC; b++) begin
      col_pat[ROWS - 1 - 8 * b -: 8] = fb_q[sel_new][IdxW'(int'(col_d) * BPC + b)];
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_curr_col     <= '0;
      o_data_col     <= '0;
      o_frame_done   <= 1'b0;
      o_frame_err    <= 1'b0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
    end else begin
      if (tick) begin
        o_curr_col <= col_d;
        o_data_col <= i_blank ? '0 : col_pat;
      end
      o_frame_done <= swap;
      o_frame_err  <= load_abort || sof_reject;
      // A frame completing on a wrap tick waits for the following wrap.
      if (load_last) begin
        swap_pending_q <= 1'b1;
      end else if (swap) begin
        swap_pending_q <= 1'b0;
      end
      front_sel_q <= front_sel_q ^ swap;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl against a frame-level reference model.
module tb_matrix_scan_ctrl;

  localparam int unsigned ROWS        = 16;
  localparam int unsigned COLS        = 4;
  localparam int unsigned SCAN_DIV    = 4;
  localparam int unsigned TIMEOUT_CYC = 40;
  localparam int unsigned NB          = 8;
  localparam int unsigned PERIOD      = SCAN_DIV * COLS;

  logic            i_clk_sys = 1'b0;
  logic            i_rst_n;
  logic            i_rx_valid;
  logic [7:0]      i_rx_data;
  logic            i_rx_perr;
  logic            i_blank;
  logic [ROWS-1:0] o_data_col;
  logic [1:0]      o_curr_col;
  logic            o_frame_done;
  logic            o_frame_err;
  logic            o_busy;

  always #5 i_clk_sys = ~i_clk_sys;

  matrix_scan_ctrl #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .SCAN_DIV    (SCAN_DIV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk_sys    (i_clk_sys),
    .i_rst_n      (i_rst_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .i_rx_perr    (i_rx_perr),
    .i_blank      (i_blank),
    .o_data_col   (o_data_col),
    .o_curr_col   (o_curr_col),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: cycle count, displayed/pending frames, frame reception
  int          n_cyc;
  int          m_col;
  int          m_idle;
  bit          m_in_frame, m_pend, m_done, m_err;
  logic [7:0]  m_q[$];
  logic [7:0]  m_back[NB];
  logic [7:0]  m_disp[NB];
  logic [15:0] m_data;
  logic [7:0]  frame_buf[NB];
  logic [15:0] exp_tab[COLS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_cyc = 0; m_col = 0; m_idle = 0;
    m_in_frame = 0; m_pend = 0; m_done = 0; m_err = 0;
    m_data = '0;
    m_q.delete();
    for (int k = 0; k < NB; k++) begin
      m_back[k] = '0;
      m_disp[k] = '0;
    end
  endtask

  task automatic model_step();
    n_cyc++;
    m_done = 0;
    m_err  = 0;
    if (n_cyc % SCAN_DIV == 0) begin
      m_col = (m_col + 1) % COLS;
      if (m_col == 0 && m_pend) begin
        for (int k = 0; k < NB; k++) m_disp[k] = m_back[k];
        m_pend = 0;
        m_done = 1;
      end
      m_data = i_blank ? 16'h0 : {m_disp[2 * m_col], m_disp[2 * m_col + 1]};
    end
    if (m_in_frame) begin
      if (i_rx_valid && i_rx_perr) begin
        m_err = 1; m_in_frame = 0;
      end else if (i_rx_valid) begin
        m_q.push_back(i_rx_data);
        m_idle = 0;
        if (m_q.size() == NB) begin
          for (int k = 0; k < NB; k++) m_back[k] = m_q[k];
          m_pend = 1;
          m_in_frame = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_err = 1; m_in_frame = 0;
        end
      end
    end else if (i_rx_valid && !i_rx_perr && i_rx_data == 8'hA5) begin
      if (m_pend) m_err = 1;
      else begin
        m_in_frame = 1; m_idle = 0; m_q.delete();
      end
    end
  endtask

  task automatic check_all();
    check("curr_col", 32'(o_curr_col), 32'(m_col));
    check("data_col", 32'(o_data_col), 32'(m_data));
    check("frame_done", 32'(o_frame_done), 32'(m_done));
    check("frame_err", 32'(o_frame_err), 32'(m_err));
    check("busy", 32'(o_busy), 32'(m_in_frame || m_pend));
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit p);
    i_rx_valid = v; i_rx_data = d; i_rx_perr = p;
    @(posedge i_clk_sys);
    model_step();
    #1;
    check_all();
    i_rx_valid = 0; i_rx_perr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_frame(input int gap_max);
    cycle(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < NB; k++) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      cycle(1'b1, frame_buf[k], 1'b0);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !m_done; i++) cycle(1'b0, 8'h00, 1'b0);
    check("frame_done_seen", 32'(o_frame_done), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data"}, 32'(o_data_col), 32'd0);
    check({tag, "_col"}, 32'(o_curr_col), 32'd0);
    check({tag, "_done"}, 32'(o_frame_done), 32'd0);
    check({tag, "_err"}, 32'(o_frame_err), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge i_clk_sys);
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_rx_valid = 0; i_rx_data = '0; i_rx_perr = 0; i_blank = 0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge i_clk_sys);
    #2;
    i_rst_n = 1'b1;

    // Blank scan after reset: 20 ticks
    idle(20 * SCAN_DIV);

    // Known frame becomes visible at the next wrap
    for (int k = 0; k < NB; k++) frame_buf[k] = 8'(8'h11 * (k + 1));
    exp_tab[0] = 16'h1122; exp_tab[1] = 16'h3344; exp_tab[2] = 16'h5566; exp_tab[3] = 16'h7788;
    send_frame(0);
    wait_done(3 * PERIOD);
    check("known_col0", 32'(o_data_col), 32'(exp_tab[0]));
    for (int c = 1; c < COLS; c++) begin
      idle(SCAN_DIV);
      check("known_col", 32'(o_data_col), 32'(exp_tab[c]));
    end

    // Parity error on the 4th payload byte aborts the frame
    cycle(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'h99, 1'b1);
    check("perr_abort", 32'(o_frame_err), 32'd1);
    idle(2 * PERIOD);

    // Inter-byte timeout
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    idle(TIMEOUT_CYC + 1);
    check("timeout_busy", 32'(o_busy), 32'd0);
    idle(PERIOD);

    // SOF while a swap is pending is rejected
    for (int i = 0; i < PERIOD && (n_cyc % PERIOD) != 0; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < NB; k++) frame_buf[k] = 8'($urandom);
    send_frame(0);
    cycle(1'b1, 8'hA5, 1'b0);
    check("sof_reject", 32'(o_frame_err), 32'd1);
    wait_done(2 * PERIOD);
    idle(PERIOD);

    // Last byte on the wrap tick: swap deferred to the following wrap
    for (int i = 0; i < PERIOD && (n_cyc % PERIOD) != 7; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < NB; k++) frame_buf[k] = 8'($urandom);
    send_frame(0);
    check("wrap_same_cycle_no_done", 32'(o_frame_done), 32'd0);
    wait_done(2 * PERIOD);
    idle(PERIOD);

    // Reset in the middle of a load
    cycle(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom), 1'b0);
    do_reset();
    for (int k = 0; k < NB; k++) frame_buf[k] = 8'($urandom);
    send_frame(2);
    wait_done(3 * PERIOD);
    idle(PERIOD);

    // Randomized frames, gaps, junk, parity errors and blanking
    for (int it = 0; it < 12; it++) begin
      i_blank = 1'($urandom_range(3, 0) == 0);
      for (int k = 0; k < NB; k++) frame_buf[k] = 8'($urandom);
      cycle(1'b1, 8'($urandom), 1'($urandom_range(1, 0)));
      cycle(1'b1, 8'hA5, 1'($urandom_range(7, 0) == 0));
      for (int k = 0; k < NB; k++) begin
        idle(int'($urandom_range(6, 0)));
        cycle(1'b1, frame_buf[k], 1'($urandom_range(15, 0) == 0));
      end
      for (int i = 0; i < 2 * PERIOD; i++) begin
        if ($urandom_range(7, 0) == 0) i_blank = ~i_blank;
        cycle(1'($urandom_range(5, 0) == 0), 8'($urandom), 1'b0);
      end
    end
    i_blank = 0;
    idle(3 * PERIOD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 16: LED rows per column; multiple of 8, range 8..64.
REQ-002 SHALL have parameter COLS, default 16: scanned columns; range 2..64.
REQ-003 SHALL have parameter SCAN_DIV, default 25000: i_clk_sys cycles per column step (2 kHz at 50 MHz).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000: maximum idle cycles between bytes inside a frame.
REQ-005 SHALL have port i_clk_sys, input, 1: system clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_rx_valid, input, 1: one-cycle pulse, received byte available.
REQ-008 SHALL have port i_rx_data, input, 8: received byte, valid with i_rx_valid.
REQ-009 SHALL have port i_rx_perr, input, 1: parity error flag, valid with i_rx_valid.
REQ-010 SHALL have port i_blank, input, 1: forces o_data_col to zero while high.
REQ-011 SHALL have port o_data_col, output, ROWS: registered row pattern for the current column.
REQ-012 SHALL have port o_curr_col, output, clog2(COLS): registered current column index.
REQ-013 SHALL have port o_frame_done, output, 1: one-cycle pulse when a frame becomes visible.
REQ-014 SHALL have port o_frame_err, output, 1: one-cycle pulse on frame abort or reject.
REQ-015 SHALL have port o_busy, output, 1: high while in LOAD or swap pending.

Function
REQ-016 SHALL hold two frame buffers (front displayed, back loaded) of COLS*BPC bytes each; BPC=ROWS/8.
REQ-017 SHALL run loader FSM IDLE->LOAD on valid byte 0xA5 with no parity error; other IDLE bytes are dropped silently.
REQ-018 SHALL in LOAD write byte k (k=0..COLS*BPC-1) to back[k]; after last byte set swap_pending and return to IDLE.
REQ-019 SHALL abort LOAD to IDLE with o_frame_err pulse on parity error or TIMEOUT_CYC cycles without i_rx_valid; back buffer is not swapped.
REQ-020 SHALL while swap_pending reject a received SOF with o_frame_err pulse, remaining in IDLE.
REQ-021 SHALL generate a scan tick every SCAN_DIV cycles; each tick increments o_curr_col, wrapping COLS-1->0.
REQ-022 SHALL on the tick where o_curr_col wraps to 0 with swap_pending set, exchange front/back, clear swap_pending, and pulse o_frame_done same cycle.
REQ-023 SHALL on each tick load o_data_col with column c=new o_curr_col: {front[c*BPC],...,front[c*BPC+BPC-1]}, first byte in MSBs; zero if i_blank.
REQ-024 SHALL use the post-swap front buffer for column 0 on the swap tick (no torn frame).
REQ-025 SHALL give frame completion priority over a same-cycle scan wrap: swap happens on the next wrap.
REQ-026 SHALL have i_blank take effect on the next tick only; o_curr_col keeps scanning.

Reset
REQ-027 SHALL on i_rst_n low asynchronously clear o_data_col, o_curr_col, o_frame_done, o_frame_err, o_busy, divider, byte counter, timeout counter, swap_pending; FSM to IDLE.
REQ-028 SHALL clear both frame buffers to zero on reset (blank display); reset mid-LOAD discards the partial frame.

Structure
REQ-029 SHALL place SOF constant 8'hA5 and FSM state encodings (IDLE, LOAD) in shared package matrix_pkg.
REQ-030 SHALL implement the SCAN_DIV divider as sub-module scan_tick (outputs one-cycle tick); loader and buffers in the top.

Verification (ROWS=16, COLS=4, SCAN_DIV=4, TIMEOUT_CYC=40)
REQ-031 SHALL cover: reset then 20 ticks -> o_curr_col 0,1,2,3,0...; o_data_col 0x0000 throughout.
REQ-032 SHALL cover: A5,11,22,33,44,55,66,77,88 -> after next wrap o_frame_done pulse; cols 0..3 show 0x1122,0x3344,0x5566,0x7788.
REQ-033 SHALL cover: A5 + 3 bytes, 4th byte perr=1 -> o_frame_err pulse; display unchanged from prior frame.
REQ-034 SHALL cover: A5 + 2 bytes then 41 idle cycles -> o_frame_err pulse, FSM IDLE, o_busy low.
REQ-035 SHALL cover: full frame then second A5 before wrap -> o_frame_err pulse; first frame displayed at wrap.
REQ-036 SHALL cover: i_rst_n low mid-LOAD -> all outputs zero immediately; next valid frame loads correctly.
